// File: rtl/global_defs.sv
// Shared project definitions: trace-op encoding, address width and request-queue entry layout.
package global_defs;

    localparam int unsigned ADDRESS_WIDTH     = 32;
    localparam int unsigned MRQ_DEPTH_DEFAULT = 16;
    localparam int unsigned MRQ_LIFE_W        = 7;

    // Parsed trace operation; NOP carries no memory request.
    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2,
        OP_FETCH = 2'd3
    } parsed_op_t;

    // Occupancy status of the request queue.
    typedef enum logic [1:0] {
        MRQ_EMPTY   = 2'd0,
        MRQ_PARTIAL = 2'd1,
        MRQ_FULL    = 2'd2
    } mrq_status_t;

    // One queued request as seen by the scheduler.
    typedef struct packed {
        logic [31:0]               cycle;
        parsed_op_t                opcode;
        logic [ADDRESS_WIDTH-1:0]  address;
        logic [MRQ_LIFE_W-1:0]     life;
    } mrq_entry_t;

endpackage

// File: rtl/mrq_age_counter.sv
// Per-slot saturating age counter; clear restarts the age at zero when a slot is rewritten.
module mrq_age_counter #(
    parameter int unsigned LIFE_W = 7
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear,
    output logic [LIFE_W-1:0] life
);

    localparam logic [LIFE_W-1:0] LIFE_MAX = '1;

    logic [LIFE_W-1:0] life_q;
    logic [LIFE_W-1:0] life_d;

    // Clear wins over increment; hold at the maximum once reached.
    always_comb begin
        life_d = life_q;
        if (clear) begin
            life_d = '0;
        end else if (life_q != LIFE_MAX) begin
            life_d = life_q + LIFE_W'(1);
        end
    end

    // Age register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            life_q <= '0;
        end else begin
            life_q <= life_d;
        end
    end

    assign life = life_q;

endmodule

// File: rtl/mem_request_queue.sv
// Request queue between the trace parser and the DRAM command scheduler.
// Circular buffer with per-slot ageing; head presented over valid/ready.
// Optional feature macro: MRQ_PEAK_EN adds peak_count (max occupancy since reset).
module mem_request_queue
    import global_defs::*;
#(
    parameter  int unsigned DEPTH  = MRQ_DEPTH_DEFAULT,
    parameter  int unsigned ADDR_W = ADDRESS_WIDTH,
    parameter  int unsigned LIFE_W = MRQ_LIFE_W,
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_cycle,
    input  logic [1:0]        in_opcode,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_cycle,
    output logic [1:0]        out_opcode,
    output logic [ADDR_W-1:0] out_addr,
    output logic [LIFE_W-1:0] out_life,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
`ifdef MRQ_PEAK_EN
    ,
    output logic [CNT_W-1:0]  peak_count
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [31:0]       cyc_q  [DEPTH];
    logic [31:0]       cyc_d  [DEPTH];
    logic [1:0]        op_q   [DEPTH];
    logic [1:0]        op_d   [DEPTH];
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [LIFE_W-1:0] slot_life [DEPTH];

    mrq_status_t status_c;
    mrq_entry_t  head_c;
    logic        push_c;
    logic        pop_c;

    // Occupancy status from the registered count only.
    always_comb begin
        status_c = MRQ_PARTIAL;
        if (count_q == '0) begin
            status_c = MRQ_EMPTY;
        end else if (count_q == CNT_W'(DEPTH)) begin
            status_c = MRQ_FULL;
        end
    end

    assign empty     = (status_c == MRQ_EMPTY);
    assign full      = (status_c == MRQ_FULL);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign count     = count_q;

    // NOP offers are accepted but never stored; pops on empty are ignored.
    assign push_c = in_valid && in_ready && (parsed_op_t'(in_opcode) != OP_NOP);
    assign pop_c  = out_valid && out_ready;

    // Pointer, count and slot payload next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        cyc_d    = cyc_q;
        op_d     = op_q;
        addr_d   = addr_q;
        if (push_c) begin
            cyc_d[wr_ptr_q]  = in_cycle;
            op_d[wr_ptr_q]   = in_opcode;
            addr_d[wr_ptr_q] = in_addr;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    // Queue state registers; reset discards every entry at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                cyc_q[i]  <= '0;
                op_q[i]   <= 2'(OP_NOP);
                addr_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            cyc_q    <= cyc_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
        end
    end

    // One age counter per slot, restarted when the slot is written.
    for (genvar i = 0; i < int'(DEPTH); i++) begin : g_age
        mrq_age_counter #(
            .LIFE_W (LIFE_W)
        ) u_age (
            .clock   (clock),
            .reset_n (reset_n),
            .clear   (push_c && (wr_ptr_q == PTR_W'(i))),
            .life    (slot_life[i])
        );
    end

    // Head entry view: direct read of the read-pointer slot.
    always_comb begin
        head_c.cycle   = cyc_q[rd_ptr_q];
        head_c.opcode  = parsed_op_t'(op_q[rd_ptr_q]);
        head_c.address = ADDRESS_WIDTH'(addr_q[rd_ptr_q]);
        head_c.life    = MRQ_LIFE_W'(slot_life[rd_ptr_q]);
    end

    assign out_cycle  = head_c.cycle;
    assign out_opcode = head_c.opcode;
    assign out_addr   = ADDR_W'(head_c.address);
    assign out_life   = LIFE_W'(head_c.life);

`ifdef MRQ_PEAK_EN
    logic [CNT_W-1:0] peak_q, peak_d;

    // Track the largest occupancy seen since reset, one cycle behind count.
    always_comb begin
        peak_d = peak_q;
        if (count_q > peak_q) begin
            peak_d = count_q;
        end
    end

    // Peak register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak_count = peak_q;
`endif

endmodule

// File: tb/tb_mem_request_queue.sv
// Self-checking bench for mem_request_queue: vector table, directed corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_mem_request_queue;

    localparam int DEPTH = 16;
    localparam int LMAX  = 127;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_cycle;
    logic [1:0]  in_opcode;
    logic [31:0] in_addr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_cycle;
    logic [1:0]  out_opcode;
    logic [31:0] out_addr;
    logic [6:0]  out_life;
    logic [4:0]  count;
    logic        full;
    logic        empty;
`ifdef MRQ_PEAK_EN
    logic [4:0]  peak_count;
`endif

    mem_request_queue dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_cycle   (in_cycle),
        .in_opcode  (in_opcode),
        .in_addr    (in_addr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_cycle  (out_cycle),
        .out_opcode (out_opcode),
        .out_addr   (out_addr),
        .out_life   (out_life),
        .count      (count),
        .full       (full),
        .empty      (empty)
`ifdef MRQ_PEAK_EN
        ,
        .peak_count (peak_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: FIFO of requests, each with its own age.
    typedef struct {
        logic [31:0] cyc;
        logic [1:0]  op;
        logic [31:0] addr;
        int          life;
    } ment_t;

    ment_t mq[$];
    int    peak_m;
    int    n_cmp;
    int    n_bad;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Compare every observable output against the model.
    task automatic check_outputs();
        chk("count", 64'(count), 64'(mq.size()));
        chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
        chk("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
        chk("full", 64'(full), 64'(mq.size() == DEPTH));
        chk("empty", 64'(empty), 64'(mq.size() == 0));
        if (mq.size() > 0) begin
            chk("out_cycle", 64'(out_cycle), 64'(mq[0].cyc));
            chk("out_opcode", 64'(out_opcode), 64'(mq[0].op));
            chk("out_addr", 64'(out_addr), 64'(mq[0].addr));
            chk("out_life", 64'(out_life), 64'(mq[0].life));
        end
`ifdef MRQ_PEAK_EN
        chk("peak_count", 64'(peak_count), 64'(peak_m));
`endif
    endtask

    // Advance the model across one rising edge.
    task automatic model_update(input logic iv, input logic [31:0] ic, input logic [1:0] iop,
                                input logic [31:0] ia, input logic ordy);
        int    sz;
        bit    do_push;
        bit    do_pop;
        ment_t e;
        sz = mq.size();
        if (sz > peak_m) peak_m = sz;
        do_pop  = ordy && (sz > 0);
        do_push = iv && (sz < DEPTH) && (iop != 2'd0);
        foreach (mq[i]) if (mq[i].life < LMAX) mq[i].life++;
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
            e.cyc = ic; e.op = iop; e.addr = ia; e.life = 0;
            mq.push_back(e);
        end
    endtask

    // Drive one cycle: check at the falling edge, clock it, return just after the edge.
    task automatic step(input logic iv, input logic [31:0] ic, input logic [1:0] iop,
                        input logic [31:0] ia, input logic ordy);
        in_valid  = iv;
        in_cycle  = ic;
        in_opcode = iop;
        in_addr   = ia;
        out_ready = ordy;
        @(negedge clock);
        check_outputs();
        @(posedge clock);
        model_update(iv, ic, iop, ia, ordy);
        #1;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 32'd0, 2'd0, 32'd0, ordy);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_opcode", 64'(out_opcode), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_out_life", 64'(out_life), 64'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        mq.delete();
        peak_m = 0;
    endtask

    typedef struct {
        logic        iv;
        logic [1:0]  op;
        logic [31:0] addr;
        logic        ordy;
        logic        exp_valid;
        int          exp_count;
        logic [31:0] exp_addr;
        int          exp_life;
    } vec_t;

    vec_t vt[8];

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        peak_m    = 0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_cycle  = '0;
        in_opcode = '0;
        in_addr   = '0;
        out_ready = 1'b0;

        vt[0] = '{1'b1, 2'd1, 32'h100, 1'b0, 1'b1, 1, 32'h100, 0};
        vt[1] = '{1'b1, 2'd2, 32'h200, 1'b0, 1'b1, 2, 32'h100, 1};
        vt[2] = '{1'b1, 2'd0, 32'h300, 1'b0, 1'b1, 2, 32'h100, 2};
        vt[3] = '{1'b0, 2'd0, 32'h000, 1'b1, 1'b1, 1, 32'h200, 2};
        vt[4] = '{1'b1, 2'd3, 32'h400, 1'b1, 1'b1, 1, 32'h400, 0};
        vt[5] = '{1'b0, 2'd0, 32'h000, 1'b1, 1'b0, 0, 32'h000, 0};
        vt[6] = '{1'b0, 2'd0, 32'h000, 1'b1, 1'b0, 0, 32'h000, 0};
        vt[7] = '{1'b1, 2'd1, 32'h500, 1'b1, 1'b1, 1, 32'h500, 0};

        @(posedge clock);
        #1;
        do_reset();

        // Vector table from an empty queue.
        for (int i = 0; i < 8; i++) begin
            step(vt[i].iv, 32'(i), vt[i].op, vt[i].addr, vt[i].ordy);
            chk($sformatf("vec%0d_count", i), 64'(count), 64'(vt[i].exp_count));
            chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(vt[i].exp_valid));
            if (vt[i].exp_valid) begin
                chk($sformatf("vec%0d_addr", i), 64'(out_addr), 64'(vt[i].exp_addr));
                chk($sformatf("vec%0d_life", i), 64'(out_life), 64'(vt[i].exp_life));
            end
        end

        // Reset while entries are resident.
        for (int i = 0; i < 3; i++) step(1'b1, 32'(50 + i), 2'd2, 32'(i * 64), 1'b0);
        do_reset();
        idle(1'b0);

        // Single READ aged for five cycles.
        step(1'b1, 32'd7, 2'd1, 32'h0000_1000, 1'b0);
        chk("t2_visible", 64'(out_valid), 64'd1);
        repeat (5) idle(1'b0);
        chk("t2_life5", 64'(out_life), 64'd5);
        chk("t2_addr", 64'(out_addr), 64'h0000_1000);
        do_reset();

        // Fill to DEPTH, reject the extra offer, drain in order.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'(100 + i), 2'd1, 32'(i * 16), 1'b0);
        chk("t3_full", 64'(full), 64'd1);
        chk("t3_in_ready", 64'(in_ready), 64'd0);
        step(1'b1, 32'd999, 2'd2, 32'hdead, 1'b0);
        chk("t3_count16", 64'(count), 64'd16);
        for (int i = 0; i < DEPTH; i++) begin
            chk("t3_order", 64'(out_cycle), 64'(100 + i));
            idle(1'b1);
        end
        chk("t3_drained", 64'(empty), 64'd1);

        // Full with simultaneous offer and pop: pop only, then the next push lands.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'(200 + i), 2'd3, 32'(i), 1'b0);
        step(1'b1, 32'd300, 2'd1, 32'h300, 1'b1);
        chk("t4_count15", 64'(count), 64'd15);
        chk("t4_head", 64'(out_cycle), 64'd201);
        step(1'b1, 32'd301, 2'd1, 32'h301, 1'b0);
        chk("t4_count16", 64'(count), 64'd16);
        do_reset();

        // Pointer wrap with steady occupancy of three.
        for (int i = 0; i < 3; i++) step(1'b1, 32'(400 + i), 2'd2, 32'(i), 1'b0);
        for (int i = 0; i < 40; i++) begin
            chk("t5_head", 64'(out_cycle), 64'(400 + i));
            step(1'b1, 32'(403 + i), 2'd2, 32'(3 + i), 1'b1);
            chk("t5_count3", 64'(count), 64'd3);
        end
        do_reset();

        // NOP offer is accepted but dropped; age saturates.
        step(1'b1, 32'd500, 2'd1, 32'h5000, 1'b0);
        chk("t6_nop_ready", 64'(in_ready), 64'd1);
        step(1'b1, 32'd501, 2'd0, 32'h5001, 1'b0);
        chk("t6_nop_count", 64'(count), 64'd1);
        repeat (200) idle(1'b0);
        chk("t6_life_sat", 64'(out_life), 64'd127);
        chk("t6_head", 64'(out_cycle), 64'd500);
        do_reset();

        // Randomized traffic with varying consumer pressure.
        for (int ph = 0; ph < 3; ph++) begin
            for (int i = 0; i < 500; i++) begin
                step(($urandom_range(0, 3) != 0), $urandom, 2'($urandom_range(0, 3)), $urandom,
                     ($urandom_range(0, 3) < ph + 1) && ($urandom_range(0, 3) != 0 || ph == 2));
            end
        end
        repeat (20) idle(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
